// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry and types for the VGA scan-out and drawing paths.
package vga_pkg;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int SCALE_LOG2 = 2;
  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int AW         = 15;
  localparam int DW         = 8;
  localparam int FB_WORDS   = FB_W * FB_H;

  typedef logic [DW-1:0] pixel_t;
  typedef logic [AW-1:0] fb_addr_t;
endpackage

// File: rtl/fb_addr_gen.sv
// Maps a screen coordinate to its frame-buffer word: (y>>2)*160 + (x>>2) via shift-add.
module fb_addr_gen
  import vga_pkg::*;
(
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic [AW-1:0] addr
);
  logic [AW-1:0] row_w;
  logic [AW-1:0] col_w;

  always_comb begin
    row_w = AW'(y >> SCALE_LOG2);
    col_w = AW'(x >> SCALE_LOG2);
    // 160 = 128 + 32
    addr  = (row_w << 7) + (row_w << 5) + col_w;
  end
endmodule

// File: rtl/fb_scheduler.sv
// Shares one frame-buffer port between fixed display-read slots and a valid/ready
// writer, and produces the 4x-upscaled pixel stream with matching sync delays.
module fb_scheduler
  import vga_pkg::*;
(
  input  logic          vgaclk,
  input  logic          reset,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pixel,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          frame_start
);
  logic          active;
  logic          disp_slot;
  logic          first_px;
  logic [AW-1:0] disp_addr;

  logic [AW-1:0] last_addr_q, last_addr_d;
  logic          rd_d1_q, rd_d1_d;
  logic          active_d1_q, active_d1_d;
  logic [DW-1:0] pix_q, pix_d;
  logic [DW-1:0] pixel_q, pixel_d;
  logic [1:0]    hs_q, hs_d;
  logic [1:0]    vs_q, vs_d;
  logic [1:0]    fs_q, fs_d;

  fb_addr_gen u_addr_gen (
    .x    (x),
    .y    (y),
    .addr (disp_addr)
  );

  always_comb begin
    active    = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
    disp_slot = active && (x[SCALE_LOG2-1:0] == '0);
    first_px  = (x == '0) && (y == '0);

    wr_ready    = ~disp_slot;
    mem_we      = 1'b0;
    mem_wdata   = wr_data;
    mem_addr    = last_addr_q;
    last_addr_d = last_addr_q;
    if (disp_slot) begin
      mem_addr    = disp_addr;
      last_addr_d = disp_addr;
    end else if (wr_valid && (wr_addr < AW'(FB_WORDS))) begin
      mem_addr = wr_addr;
      mem_we   = 1'b1;
    end

    // Read data lands one cycle after the slot; hold it for the other three columns.
    rd_d1_d     = disp_slot;
    active_d1_d = active;
    pix_d       = rd_d1_q ? mem_rdata : pix_q;
    pixel_d     = active_d1_q ? pix_d : '0;
    hs_d        = {hs_q[0], hsync_in};
    vs_d        = {vs_q[0], vsync_in};
    fs_d        = {fs_q[0], first_px};
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      last_addr_q <= '0;
      rd_d1_q     <= 1'b0;
      active_d1_q <= 1'b0;
      pix_q       <= '0;
      pixel_q     <= '0;
      hs_q        <= 2'b11;
      vs_q        <= 2'b11;
      fs_q        <= 2'b00;
    end else begin
      last_addr_q <= last_addr_d;
      rd_d1_q     <= rd_d1_d;
      active_d1_q <= active_d1_d;
      pix_q       <= pix_d;
      pixel_q     <= pixel_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
    end
  end

  assign pixel       = pixel_q;
  assign hsync_out   = hs_q[1];
  assign vsync_out   = vs_q[1];
  assign frame_start = fs_q[1];
endmodule

// File: tb/tb_fb_scheduler.sv
// Directed bench for fb_scheduler with a behavioural single-port RAM behind it.
module tb_fb_scheduler;
  import vga_pkg::*;

  logic          vgaclk = 1'b0;
  logic          reset;
  logic [9:0]    x, y;
  logic          hsync_in, vsync_in;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pixel;
  logic          hsync_out, vsync_out, frame_start;

  logic [DW-1:0] ram [0:FB_WORDS-1];
  int            we_cnt = 0;
  int            n_cmp  = 0;
  int            n_fail = 0;
  int            base;

  always #5 vgaclk = ~vgaclk;

  always @(posedge vgaclk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_cnt        <= we_cnt + 1;
    end
    mem_rdata <= ram[mem_addr];
  end

  fb_scheduler dut (
    .vgaclk      (vgaclk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pixel       (pixel),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [9:0] xi, input logic [9:0] yi);
    @(posedge vgaclk);
    #1;
    x = xi;
    y = yi;
    #1;
  endtask

  task automatic wr_blank(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc(10'd700, 10'd0);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    check("pre_rdy", 32'(wr_ready), 32'd1);
    check("pre_we", 32'(mem_we), 32'd1);
    cyc(10'd701, 10'd0);
    wr_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    x        = 10'd700;
    y        = 10'd500;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    #3;
    check("rst_pixel", 32'(pixel), 32'h0);
    check("rst_hs", 32'(hsync_out), 32'd1);
    check("rst_vs", 32'(vsync_out), 32'd1);
    check("rst_fs", 32'(frame_start), 32'd0);
    #15;
    check("rst_pixel2", 32'(pixel), 32'h0);
    check("rst_hs2", 32'(hsync_out), 32'd1);
    #2;
    reset    = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;

    wr_blank(15'd0, 8'hE0);
    wr_blank(15'd1, 8'h1C);
    wr_blank(15'd19199, 8'h3C);
    wr_blank(15'd8075, 8'h11);
    wr_blank(15'd8076, 8'h93);
    $display("preload done, writes=%0d", we_cnt);
    base = we_cnt;

    // Row 0 sweep with a write colliding with the x=8 slot
    for (int k = 0; k < 12; k++) begin
      cyc(10'(k), 10'd0);
      if (k == 0) check("addr_x0", 32'(mem_addr), 32'd0);
      if (k == 4) check("addr_x4", 32'(mem_addr), 32'd1);
      if (k >= 1 && k <= 3) check($sformatf("fs_k%0d", k), 32'(frame_start), 32'(k == 2));
      if (k >= 2 && k <= 5) check($sformatf("pix_k%0d", k), 32'(pixel), 32'hE0);
      if (k >= 6 && k <= 9) check($sformatf("pix_k%0d", k), 32'(pixel), 32'h1C);
      if (k == 8) begin
        wr_valid = 1'b1;
        wr_addr  = 15'd100;
        wr_data  = 8'h55;
        #1;
        check("slot_rdy", 32'(wr_ready), 32'd0);
        check("slot_we", 32'(mem_we), 32'd0);
        check("slot_addr", 32'(mem_addr), 32'd2);
      end
      if (k == 9) begin
        check("wr_rdy", 32'(wr_ready), 32'd1);
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'd100);
        check("wr_data", 32'(mem_wdata), 32'h55);
      end
      if (k == 10) begin
        wr_valid = 1'b0;
        #1;
        check("wr_done_we", 32'(mem_we), 32'd0);
      end
      $display("sweep y=0 x=%0d pixel=%0h addr=%0d we=%0b rdy=%0b", k, pixel, mem_addr, mem_we, wr_ready);
    end
    check("wr_once", 32'(we_cnt - base), 32'd1);
    check("ram100", 32'(ram[100]), 32'h55);

    // Out-of-range write during blanking is accepted and dropped
    cyc(10'd700, 10'd0);
    wr_valid = 1'b1;
    wr_addr  = 15'd19200;
    wr_data  = 8'hAA;
    #1;
    check("oor_rdy", 32'(wr_ready), 32'd1);
    check("oor_we", 32'(mem_we), 32'd0);
    check("oor_addr", 32'(mem_addr), 32'd2);
    cyc(10'd701, 10'd0);
    wr_valid = 1'b0;
    check("oor_cnt", 32'(we_cnt - base), 32'd1);
    $display("oor write addr=19200 dropped");

    // Sync delay
    cyc(10'd656, 10'd0);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    cyc(10'd657, 10'd0);
    check("hs_d1", 32'(hsync_out), 32'd1);
    cyc(10'd658, 10'd0);
    check("hs_d2", 32'(hsync_out), 32'd0);
    check("vs_d2", 32'(vsync_out), 32'd0);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    $display("sync delay checked");

    // Last visible word and start of blanking
    for (int k = 636; k < 646; k++) begin
      cyc(10'(k), 10'd479);
      if (k == 636) begin
        check("last_addr", 32'(mem_addr), 32'd19199);
        check("last_rdy", 32'(wr_ready), 32'd0);
      end
      if (k == 639) check("hold_addr", 32'(mem_addr), 32'd19199);
      if (k >= 637) check($sformatf("rdy_x%0d", k), 32'(wr_ready), 32'd1);
      if (k >= 638 && k <= 641) check($sformatf("pix_x%0d", k), 32'(pixel), 32'h3C);
      if (k >= 642) check($sformatf("pix_x%0d", k), 32'(pixel), 32'h0);
      $display("sweep y=479 x=%0d pixel=%0h addr=%0d rdy=%0b", k, pixel, mem_addr, wr_ready);
    end

    // Mid-frame reset and realignment
    hsync_in = 1'b0;
    for (int k = 296; k < 312; k++) begin
      cyc(10'(k), 10'd200);
      if (k == 299) check("hs_pre_rst", 32'(hsync_out), 32'd0);
      if (k == 300) begin
        reset = 1'b1;
        #1;
        check("mrst_pixel", 32'(pixel), 32'h0);
        check("mrst_hs", 32'(hsync_out), 32'd1);
      end
      if (k == 301) check("mrst_fs", 32'(frame_start), 32'd0);
      if (k == 303) reset = 1'b0;
      if (k == 304) begin
        check("re_addr", 32'(mem_addr), 32'd8076);
        check("re_rdy", 32'(wr_ready), 32'd0);
      end
      if (k == 305) check("re_pix_gap", 32'(pixel), 32'h0);
      if (k >= 306 && k <= 309) check($sformatf("re_pix_x%0d", k), 32'(pixel), 32'h93);
      $display("sweep y=200 x=%0d rst=%0b pixel=%0h addr=%0d", k, reset, pixel, mem_addr);
    end
    hsync_in = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
